id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register. It sits directly downstream of the ID-stage flush gating and feeds the EX stage (ALU, forwarding and branch/JR resolution).
- It captures post-flush control bits plus ID datapath values each cycle.
- It supports a hazard-unit stall (hold) and a bubble insert (flush).
- A saturating stall watchdog flags a stuck pipeline.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/ex_ctrl_reg.sv | 40 ++++
 rtl/id_ex_pipe_reg.sv | 144 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the ID/EX boundary: the packed control word,
// the bubble constant and the default datapath widths.
package pipeline_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;

  // Control bits, MSB first, in the same order as the 11-bit id_ctrl bus.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_src;
    logic       jr_control;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ex_ctrl_reg.sv
// EX-stage control register: holds the control word and the valid bit.
// A flush or an invalid ID slot loads a bubble, so nothing downstream can
// write registers or memory for a non-instruction.
module ex_ctrl_reg
  import pipeline_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  flush,
  input  logic  id_valid,
  input  ctrl_t id_ctrl,
  output logic  ex_valid,
  output ctrl_t ex_ctrl
);

  logic  valid_r;
  ctrl_t ctrl_r;

  // Control/valid update with priority reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      ctrl_r  <= CTRL_NOP;
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= CTRL_NOP;
    end else if (stall) begin
      valid_r <= valid_r;
      ctrl_r  <= ctrl_r;
    end else begin
      valid_r <= id_valid;
      ctrl_r  <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  assign ex_valid = valid_r;
  assign ex_ctrl  = ctrl_r;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hazard stall (hold), flush (bubble) and a
// saturating stall watchdog. Optional performance counters are enabled by
// defining the macro ID_EX_PERF_EN.
module id_ex_pipe_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
  parameter int STALL_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [10:0]           id_ctrl,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  ex_valid,
  output logic [10:0]           ex_ctrl,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef ID_EX_PERF_EN
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_stalls,
`endif
  output logic                  stall_timeout
);

  localparam logic [7:0] LIMIT_C = 8'(STALL_LIMIT);

  ctrl_t      ex_ctrl_s;
  logic [7:0] stall_cnt_r;
  logic [7:0] stall_cnt_next_s;
  logic       stall_timeout_r;

  ex_ctrl_reg u_ex_ctrl_reg (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .id_valid (id_valid),
    .id_ctrl  (ctrl_t'(id_ctrl)),
    .ex_valid (ex_valid),
    .ex_ctrl  (ex_ctrl_s)
  );

  assign ex_ctrl = ex_ctrl_s;

  // Datapath fields: loaded on flush too, so bubbles carry deterministic data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_pc4 <= '0;
      ex_rd1 <= '0;
      ex_rd2 <= '0;
      ex_imm <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_rd  <= '0;
    end else if (flush || !stall) begin
      ex_pc4 <= id_pc4;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      ex_imm <= id_imm;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_rd  <= id_rd;
    end else begin
      ex_pc4 <= ex_pc4;
      ex_rd1 <= ex_rd1;
      ex_rd2 <= ex_rd2;
      ex_imm <= ex_imm;
      ex_rs  <= ex_rs;
      ex_rt  <= ex_rt;
      ex_rd  <= ex_rd;
    end
  end

  // Next consecutive-stall count: counts only true holds, saturates at 255.
  always_comb begin
    stall_cnt_next_s = 8'd0;
    if (stall && !flush) begin
      if (stall_cnt_r == 8'hFF) begin
        stall_cnt_next_s = 8'hFF;
      end else begin
        stall_cnt_next_s = stall_cnt_r + 8'd1;
      end
    end else begin
      stall_cnt_next_s = 8'd0;
    end
  end

  // Watchdog state; timeout is registered from the next count so it rises
  // on the very edge that counts the limit-th stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r     <= 8'd0;
      stall_timeout_r <= 1'b0;
    end else begin
      stall_cnt_r     <= stall_cnt_next_s;
      stall_timeout_r <= (stall_cnt_next_s >= LIMIT_C);
    end
  end

  assign stall_timeout = stall_timeout_r;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles_r;
  logic [31:0] perf_stalls_r;

  // Bubble and stall event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles_r <= 32'd0;
      perf_stalls_r  <= 32'd0;
    end else begin
      if (flush || (!stall && !id_valid)) begin
        perf_bubbles_r <= perf_bubbles_r + 32'd1;
      end else begin
        perf_bubbles_r <= perf_bubbles_r;
      end
      if (stall && !flush) begin
        perf_stalls_r <= perf_stalls_r + 32'd1;
      end else begin
        perf_stalls_r <= perf_stalls_r;
      end
    end
  end

  assign perf_bubbles = perf_bubbles_r;
  assign perf_stalls  = perf_stalls_r;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (STALL_LIMIT=4): directed plan
// scenarios followed by randomized traffic, all against a behavioural model.
module tb_id_ex_pipe_reg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset, stall, flush, id_valid;
  logic [10:0]   id_ctrl;
  logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          ex_valid, stall_timeout;
  logic [10:0]   ex_ctrl;
  logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_PERF_EN
  logic [31:0]   perf_bubbles, perf_stalls;
`endif

  id_ex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
`ifdef ID_EX_PERF_EN
    .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls),
`endif
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  // Reference model state: "what EX should hold" after each edge.
  logic          m_valid;
  logic [10:0]   m_ctrl;
  logic [DW-1:0] m_pc4, m_rd1, m_rd2, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  int            m_run;       // consecutive held cycles, unbounded
  longint        m_bubbles, m_stalls;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_valid = 1'b0; m_ctrl = 11'd0;
      m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0;
      m_run = 0; m_bubbles = 0; m_stalls = 0;
    end else if (flush || !stall) begin
      m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_valid = flush ? 1'b0 : id_valid;
      m_ctrl  = m_valid ? id_ctrl : 11'd0;
      if (!m_valid) m_bubbles++;
      m_run = 0;
    end else begin
      m_run++;
      m_stalls++;
    end
  endtask

  task automatic compare_all();
    check_eq("ex_valid", 64'(ex_valid), 64'(m_valid));
    check_eq("ex_ctrl",  64'(ex_ctrl),  64'(m_ctrl));
    check_eq("ex_pc4",   64'(ex_pc4),   64'(m_pc4));
    check_eq("ex_rd1",   64'(ex_rd1),   64'(m_rd1));
    check_eq("ex_rd2",   64'(ex_rd2),   64'(m_rd2));
    check_eq("ex_imm",   64'(ex_imm),   64'(m_imm));
    check_eq("ex_rs",    64'(ex_rs),    64'(m_rs));
    check_eq("ex_rt",    64'(ex_rt),    64'(m_rt));
    check_eq("ex_rd",    64'(ex_rd),    64'(m_rd));
    check_eq("stall_timeout", 64'(stall_timeout), 64'(m_run >= LIMIT));
`ifdef ID_EX_PERF_EN
    check_eq("perf_bubbles", 64'(perf_bubbles), 64'(m_bubbles % 64'h1_0000_0000));
    check_eq("perf_stalls",  64'(perf_stalls),  64'(m_stalls % 64'h1_0000_0000));
`endif
  endtask

  // One clock: model the edge, then sample outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_data();
    id_ctrl = 11'($urandom);
    id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    rand_data();
    // Reset for two cycles: everything zero.
    tick(); tick();
    check_eq("reset_valid", 64'(ex_valid), 64'd0);
    check_eq("reset_ctrl", 64'(ex_ctrl), 64'd0);
    check_eq("reset_rd1", 64'(ex_rd1), 64'd0);

    // Reset then load.
    reset = 1'b0; id_valid = 1'b1; id_ctrl = 11'h4C2; id_rd1 = 32'hDEADBEEF; id_rt = 5'd9;
    tick();
    check_eq("load_ctrl", 64'(ex_ctrl), 64'h4C2);
    check_eq("load_rd1", 64'(ex_rd1), 64'hDEADBEEF);
    check_eq("load_rt", 64'(ex_rt), 64'd9);
    check_eq("load_valid", 64'(ex_valid), 64'd1);

    // Flush with all control bits set: bubble, but data still loaded.
    flush = 1'b1; id_ctrl = 11'h7FF; id_rd2 = 32'h1234_5678;
    tick();
    check_eq("flush_ctrl", 64'(ex_ctrl), 64'd0);
    check_eq("flush_valid", 64'(ex_valid), 64'd0);
    check_eq("flush_rd2", 64'(ex_rd2), 64'h1234_5678);
    flush = 1'b0;

    // Stall hold of ex_imm while id_imm changes.
    id_imm = 32'h10; id_ctrl = 11'h155;
    tick();
    stall = 1'b1; id_imm = 32'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_hold_imm", 64'(ex_imm), 64'h10);
    end
    stall = 1'b0;
    tick();
    check_eq("stall_release_imm", 64'(ex_imm), 64'h20);

    // id_valid=0 load forces control to zero.
    id_valid = 1'b0; id_ctrl = 11'h7FF;
    tick();
    check_eq("invalid_ctrl", 64'(ex_ctrl), 64'd0);
    id_valid = 1'b1;

    // Watchdog: 6 stalls, timeout from the 4th, gone one edge after release.
    stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("wdog_timeout", 64'(stall_timeout), 64'(i >= 4));
    end
    stall = 1'b0;
    tick();
    check_eq("wdog_release", 64'(stall_timeout), 64'd0);

    // Stall built up past the limit, then flush+stall together: bubble, count clears.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    check_eq("fs_valid", 64'(ex_valid), 64'd0);
    check_eq("fs_timeout", 64'(stall_timeout), 64'd0);
    flush = 1'b0;
    tick();
    check_eq("fs_recount", 64'(stall_timeout), 64'd0);

    // Reset mid-stall dominates.
    reset = 1'b1;
    tick();
    check_eq("rst_mid_valid", 64'(ex_valid), 64'd0);
    reset = 1'b0; stall = 1'b0;

`ifdef ID_EX_PERF_EN
    // Perf plan: from reset, 2 flushes, 1 invalid load, 5 stalls.
    reset = 1'b1; tick(); reset = 1'b0;
    id_valid = 1'b1; flush = 1'b1; tick(); tick(); flush = 1'b0;
    id_valid = 1'b0; tick(); id_valid = 1'b1;
    stall = 1'b1; for (int i = 0; i < 5; i++) tick(); stall = 1'b0;
    check_eq("perf_bubbles_plan", 64'(perf_bubbles), 64'd3);
    check_eq("perf_stalls_plan", 64'(perf_stalls), 64'd5);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("perf_bubbles_rst", 64'(perf_bubbles), 64'd0);
    check_eq("perf_stalls_rst", 64'(perf_stalls), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      stall    = ($urandom_range(0, 99) < 45);
      flush    = ($urandom_range(0, 99) < 12);
      id_valid = ($urandom_range(0, 99) < 80);
      rand_data();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
